// File: rtl/note_stream_pingpong_sink_if.sv
// Note-word stream between the note source and the ping-pong sink.
// The source drives one word per in_valid strobe; in_sof marks the first word of a frame.
interface note_stream_pingpong_sink_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_sof;

    modport master (
        output in_valid,
        output in_data,
        output in_sof
    );

    modport slave (
        input in_valid,
        input in_data,
        input in_sof
    );
endinterface

// File: rtl/note_stream_pingpong_sink.sv
// Ping-pong frame buffer for the note-row stream.
// One bank fills from the stream while the drawer reads the other, completed bank.
// Banks swap only when a full frame has landed and the reader is not holding its bank.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// FILL      | accepting words into the write bank; in_sof restarts at address 0
// WAIT_SWAP | write bank full, reader holds its bank; incoming words are dropped
module note_stream_pingpong_sink #(
    parameter int DW    = 8,
    parameter int AW    = 5,
    parameter int DEPTH = 32
) (
    input  logic                              clk,
    input  logic                              resetn,
    note_stream_pingpong_sink_if.slave        in_bus,
    input  logic                              rd_lock,
    input  logic [AW-1:0]                     rd_addr,
    output logic [DW-1:0]                     rd_data,
    output logic                              frame_valid,
    output logic                              frame_ready,
    output logic                              rd_bank,
    output logic                              overflow,
    input  logic                              overflow_clr
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE       = AW'(1);

    typedef enum logic [0:0] {
        FILL      = 1'b0,
        WAIT_SWAP = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             wr_bank;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    wr_ptr_next;
    logic [AW-1:0]    wr_addr;
    logic             wr_en;
    logic             swap;
    logic             drop;

    // Both banks live in one array; the bank index is the address MSB.
    logic [DW-1:0]    mem [0:2*DEPTH-1];

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the write, swap and drop decisions for this cycle.
    always_comb begin
        state_next  = state;
        wr_ptr_next = wr_ptr;
        wr_addr     = wr_ptr;
        wr_en       = 1'b0;
        swap        = 1'b0;
        drop        = 1'b0;
        case (state)
            FILL: begin
                if (in_bus.in_sof) begin
                    // A new frame start abandons any partial frame without a swap.
                    wr_ptr_next = '0;
                    if (in_bus.in_valid) begin
                        wr_en       = 1'b1;
                        wr_addr     = '0;
                        wr_ptr_next = ONE;
                    end
                end else if (in_bus.in_valid) begin
                    wr_en       = 1'b1;
                    wr_addr     = wr_ptr;
                    wr_ptr_next = wr_ptr + ONE;
                end
                if (wr_en && (wr_addr == LAST_ADDR)) begin
                    wr_ptr_next = '0;
                    if (!rd_lock) begin
                        swap = 1'b1;
                    end else begin
                        state_next = WAIT_SWAP;
                    end
                end
            end
            WAIT_SWAP: begin
                // Nothing is written here, including the cycle that finally swaps.
                drop = in_bus.in_valid;
                if (!rd_lock) begin
                    swap       = 1'b1;
                    state_next = FILL;
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    // Bank bookkeeping, frame flags and sticky overflow.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b1;
            wr_ptr      <= '0;
            frame_valid <= 1'b0;
            frame_ready <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_next;
            frame_ready <= swap;
            if (swap) begin
                rd_bank     <= wr_bank;
                wr_bank     <= ~wr_bank;
                frame_valid <= 1'b1;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Write port; contents survive reset, and no writes land while reset is held.
    always_ff @(posedge clk) begin
        if (resetn && wr_en) begin
            mem[{wr_bank, wr_addr}] <= in_bus.in_data;
        end
    end

    // Registered read from the pre-edge read bank; zero until the first frame lands.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_data <= '0;
        end else if (frame_valid) begin
            rd_data <= mem[{rd_bank, rd_addr}];
        end else begin
            rd_data <= '0;
        end
    end

endmodule
